// File: rtl/dtb_pkg.sv
// Shared types and default sizing for the trace-buffer memory controller.
package dtb_pkg;

  localparam int TRB_WIDTH = 32;
  localparam int TRB_DEPTH = 8;
  localparam int TRB_AW    = $clog2(TRB_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRC_ACC,
    ST_TRC_ACK,
    ST_TRC_REL,
    ST_HOST_ACC,
    ST_HOST_VAL,
    ST_CLEAR
  } mem_state_t;

  // Tracer exchange captured in ST_IDLE and replayed in ST_TRC_ACC.
  typedef struct packed {
    logic [TRB_AW-1:0]    rd_addr;
    logic [TRB_AW-1:0]    wr_addr;
    logic [TRB_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/trb_mem_array.sv
// Plain synchronous read-first RAM, one write and one read port; drop-in point for vendor BRAM.
module trb_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read and write in one block so a same-address access returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trb_mem_ctrl.sv
// Trace memory controller: tracer write-then-read exchange, host reads, clear sweep.
// Optional even parity per word when TRB_MEM_PARITY_EN is defined (adds PARITY_ERR_O).
module trb_mem_ctrl
  import dtb_pkg::*;
#(
  parameter int WIDTH = TRB_WIDTH,
  parameter int DEPTH = TRB_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             FPGA_CLK_I,
  input  logic             RST_,
  input  logic             RW_I,
  input  logic [AW-1:0]    READ_ADDR_I,
  input  logic [AW-1:0]    WRITE_ADDR_I,
  input  logic [WIDTH-1:0] DATA_I,
  output logic [WIDTH-1:0] DATA_O,
  output logic             ACK_O,
  input  logic             HOST_REQ_I,
  input  logic [AW-1:0]    HOST_ADDR_I,
  output logic [WIDTH-1:0] HOST_DATA_O,
  output logic             HOST_VALID_O,
  input  logic             CLEAR_I,
`ifdef TRB_MEM_PARITY_EN
  output logic             PARITY_ERR_O,
`endif
  output logic             BUSY_O
);

`ifdef TRB_MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  mem_state_t       state_q, state_d;
  mem_req_t         req_q, req_d;
  logic [AW-1:0]    host_addr_q, host_addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] hdata_q, hdata_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             clr_pend_q, clr_pend_d;
  logic             dispatch;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [MW-1:0]    ram_wdata, ram_rdata, trc_word;
  logic [WIDTH-1:0] req_wdata, rd_word;
  logic             sweep_last;

  assign req_wdata  = WIDTH'(req_q.wdata);
  assign rd_word    = ram_rdata[WIDTH-1:0];
  assign sweep_last = (state_q == ST_CLEAR) && (cnt_q == AW'(DEPTH - 1));

`ifdef TRB_MEM_PARITY_EN
  assign trc_word = {^req_wdata, req_wdata};
`else
  assign trc_word = req_wdata;
`endif

  trb_mem_array #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (FPGA_CLK_I),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    host_addr_d = host_addr_q;
    data_d      = data_q;
    hdata_d     = hdata_q;
    cnt_d       = cnt_q;
    clr_pend_d  = clr_pend_q;
    dispatch    = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    ram_raddr   = '0;

    if (CLEAR_I && (state_q != ST_IDLE) && (state_q != ST_CLEAR)) begin
      clr_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: dispatch = 1'b1;
      ST_TRC_ACC: begin
        ram_we    = 1'b1;
        ram_waddr = AW'(req_q.wr_addr);
        ram_wdata = trc_word;
        ram_raddr = AW'(req_q.rd_addr);
        state_d   = ST_TRC_ACK;
      end
      ST_TRC_ACK: begin
        data_d  = rd_word;
        state_d = ST_TRC_REL;
      end
      // Once the tracer lets go, serve anything queued without an extra idle cycle.
      ST_TRC_REL: begin
        if (!RW_I) begin
          state_d  = ST_IDLE;
          dispatch = 1'b1;
        end
      end
      ST_HOST_ACC: begin
        ram_raddr = host_addr_q;
        state_d   = ST_HOST_VAL;
      end
      ST_HOST_VAL: begin
        hdata_d = rd_word;
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        cnt_d     = cnt_q + AW'(1);
        if (sweep_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (dispatch) begin
      if (CLEAR_I || clr_pend_q) begin
        state_d    = ST_CLEAR;
        clr_pend_d = 1'b0;
      end else if (RW_I) begin
        state_d       = ST_TRC_ACC;
        req_d.rd_addr = TRB_AW'(READ_ADDR_I);
        req_d.wr_addr = TRB_AW'(WRITE_ADDR_I);
        req_d.wdata   = TRB_WIDTH'(DATA_I);
      end else if (HOST_REQ_I) begin
        state_d     = ST_HOST_ACC;
        host_addr_d = HOST_ADDR_I;
      end
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RST_) begin
    if (!RST_) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      host_addr_q <= '0;
      data_q      <= '0;
      hdata_q     <= '0;
      cnt_q       <= '0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      host_addr_q <= host_addr_d;
      data_q      <= data_d;
      hdata_q     <= hdata_d;
      cnt_q       <= cnt_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  // Read data is shown straight from the RAM in the pulse cycle, then held.
  assign ACK_O        = (state_q == ST_TRC_ACK);
  assign DATA_O       = ACK_O ? rd_word : data_q;
  assign HOST_VALID_O = (state_q == ST_HOST_VAL);
  assign HOST_DATA_O  = HOST_VALID_O ? rd_word : hdata_q;
  assign BUSY_O       = (state_q == ST_CLEAR);

`ifdef TRB_MEM_PARITY_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((ACK_O || HOST_VALID_O) && (^ram_rdata)) begin
      err_d = 1'b1;
    end
    if (sweep_last) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RST_) begin
    if (!RST_) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign PARITY_ERR_O = err_q;
`endif

endmodule

// File: tb/tb_trb_mem_ctrl.sv
// Self-checking bench for trb_mem_ctrl: vector table plus multi-cycle corner sequences.
// Define TRB_MEM_PARITY_EN to also exercise the parity path.
module tb_trb_mem_ctrl;
  import dtb_pkg::*;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rw = 1'b0;
  logic          host_req = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] host_addr = '0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out, host_data;
  logic          ack, host_valid, busy;
`ifdef TRB_MEM_PARITY_EN
  logic          parity_err;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] trc_q[$];
  logic [W-1:0] host_q[$];
  logic [W-1:0] model[D];

  typedef struct {
    bit            is_host;
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [W-1:0]  wd;
    logic [W-1:0]  exp;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  trb_mem_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .FPGA_CLK_I   (clk),
    .RST_         (rst_n),
    .RW_I         (rw),
    .READ_ADDR_I  (rd_addr),
    .WRITE_ADDR_I (wr_addr),
    .DATA_I       (data_in),
    .DATA_O       (data_out),
    .ACK_O        (ack),
    .HOST_REQ_I   (host_req),
    .HOST_ADDR_I  (host_addr),
    .HOST_DATA_O  (host_data),
    .HOST_VALID_O (host_valid),
    .CLEAR_I      (clear),
`ifdef TRB_MEM_PARITY_EN
    .PARITY_ERR_O (parity_err),
`endif
    .BUSY_O       (busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard: every ACK/HOST_VALID pulse pops the oldest expectation of its kind.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (trc_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_ack: ACK_O=1 with DATA_O=%h, expected no pulse", data_out);
      end else begin
        check("trc_data", data_out, trc_q.pop_front());
      end
    end
    if (rst_n && host_valid) begin
      if (host_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_host_valid: HOST_VALID_O=1 with %h, expected no pulse", host_data);
      end else begin
        check("host_data", host_data, host_q.pop_front());
      end
    end
  end

  task automatic trc_xfer(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                          input logic [W-1:0] wd, input logic [W-1:0] exp);
    int lat;
    trc_q.push_back(exp);
    model[wa] = wd;
    rd_addr = ra; wr_addr = wa; data_in = wd; rw = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack && lat < 20);
    check_int("trc_latency", lat, 2);
    rw = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic host_rd(input logic [AW-1:0] a, input logic [W-1:0] exp);
    int lat;
    host_q.push_back(exp);
    host_addr = a; host_req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!host_valid && lat < 20);
    check_int("host_latency", lat, 2);
    host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear(output int busy_cycles);
    int n;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (busy && n < 100) begin busy_cycles++; @(negedge clk); n++; end
    for (int i = 0; i < D; i++) model[i] = '0;
  endtask

  initial begin
    int bc, t, ack_t, hv_t, fall_t, acks;
`ifdef TRB_MEM_PARITY_EN
    logic [W:0] flip;
`endif
    vecs[0]  = '{1'b0, 3'd4, 3'd3, 32'hA5A5A5A5, 32'h00000000};
    vecs[1]  = '{1'b1, 3'd3, 3'd0, 32'h0,        32'hA5A5A5A5};
    vecs[2]  = '{1'b0, 3'd5, 3'd5, 32'h00000007, 32'h00000000};
    vecs[3]  = '{1'b0, 3'd5, 3'd5, 32'h00000009, 32'h00000007};
    vecs[4]  = '{1'b1, 3'd5, 3'd0, 32'h0,        32'h00000009};
    vecs[5]  = '{1'b0, 3'd3, 3'd0, 32'h12345678, 32'hA5A5A5A5};
    vecs[6]  = '{1'b1, 3'd0, 3'd0, 32'h0,        32'h12345678};
    vecs[7]  = '{1'b0, 3'd7, 3'd7, 32'hFFFFFFFF, 32'h00000000};
    vecs[8]  = '{1'b1, 3'd7, 3'd0, 32'h0,        32'hFFFFFFFF};
    vecs[9]  = '{1'b0, 3'd0, 3'd6, 32'hDEADBEEF, 32'h12345678};
    vecs[10] = '{1'b1, 3'd6, 3'd0, 32'h0,        32'hDEADBEEF};

    repeat (3) @(negedge clk);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_host_valid", {31'd0, host_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data_o", data_out, 32'd0);
    check("reset_host_data_o", host_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_clear(bc);
    check_int("clear_busy_cycles", bc, D);

    foreach (vecs[i]) begin
      if (vecs[i].is_host) host_rd(vecs[i].rd, vecs[i].exp);
      else                 trc_xfer(vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].exp);
    end

    // Held request: exactly one ACK until RW_I toggles.
    trc_q.push_back(model[1]);
    model[2] = 32'h0000600D;
    rd_addr = 3'd1; wr_addr = 3'd2; data_in = 32'h0000600D; rw = 1'b1;
    acks = 0;
    repeat (6) begin @(negedge clk); if (ack) acks++; end
    check_int("held_rw_ack_count", acks, 1);
    rw = 1'b0;
    repeat (2) @(negedge clk);
    trc_xfer(3'd2, 3'd1, 32'h0BADF00D, model[2]);

    // Tracer and host together: tracer first, host valid three cycles after ACK.
    trc_q.push_back(model[4]);
    model[3] = 32'hCAFE0003;
    host_q.push_back(32'hCAFE0003);
    rd_addr = 3'd4; wr_addr = 3'd3; data_in = 32'hCAFE0003; host_addr = 3'd3;
    rw = 1'b1; host_req = 1'b1;
    t = 0; ack_t = -1; hv_t = -1;
    while (t < 30 && hv_t < 0) begin
      @(negedge clk); t++;
      if (ack && ack_t < 0) begin ack_t = t; rw = 1'b0; end
      if (host_valid) begin hv_t = t; host_req = 1'b0; end
    end
    rw = 1'b0; host_req = 1'b0;
    check_int("both_ack_cycle", ack_t, 2);
    check_int("both_host_valid_cycle", hv_t, 5);
    @(negedge clk);

    // Clear sweep with a tracer request arriving in sweep cycle 2.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    bc = 0; fall_t = -1; ack_t = -1;
    for (t = 0; t < 40; t++) begin
      if (busy) bc++;
      else if (fall_t < 0) fall_t = t;
      if (ack) begin ack_t = t; break; end
      if (t == 1) begin
        trc_q.push_back(model[3]);
        model[4] = 32'h44444444;
        rd_addr = 3'd3; wr_addr = 3'd4; data_in = 32'h44444444; rw = 1'b1;
      end
      @(negedge clk);
    end
    rw = 1'b0;
    check_int("sweep_busy_cycles", bc, D);
    check_int("sweep_ack_after_fall", ack_t - fall_t, 2);
    repeat (2) @(negedge clk);
    host_rd(3'd4, 32'h44444444);
    host_rd(3'd7, 32'h0);

    // Clear pulsed mid-exchange is remembered and runs afterwards.
    trc_q.push_back(model[4]);
    model[5] = 32'h55555555;
    rd_addr = 3'd4; wr_addr = 3'd5; data_in = 32'h55555555; rw = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    t = 0;
    while (!ack && t < 10) begin @(negedge clk); t++; end
    rw = 1'b0;
    t = 0;
    while (!busy && t < 10) begin @(negedge clk); t++; end
    bc = 0;
    while (busy && bc < 100) begin bc++; @(negedge clk); end
    check_int("pending_clear_busy_cycles", bc, D);
    for (int i = 0; i < D; i++) model[i] = '0;
    host_rd(3'd5, 32'h0);

`ifdef TRB_MEM_PARITY_EN
    trc_xfer(3'd0, 3'd2, 32'h00000013, model[0]);
    check("parity_err_clean", {31'd0, parity_err}, 32'd0);
    flip = dut.u_array.mem_q[2];
    flip[0] = ~flip[0];
    force dut.u_array.mem_q[2] = flip;
    @(negedge clk);
    release dut.u_array.mem_q[2];
    host_rd(3'd2, 32'h00000012);
    check("parity_err_set", {31'd0, parity_err}, 32'd1);
    repeat (5) @(negedge clk);
    check("parity_err_sticky", {31'd0, parity_err}, 32'd1);
    do_clear(bc);
    check("parity_err_cleared", {31'd0, parity_err}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check_int("scoreboard_drained", trc_q.size() + host_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
